instr_fetch_unit: RTL and testbench



---
 rtl/instr_fetch_unit.sv | 150 +++++++++++++++
 tb/tb_instr_fetch_unit.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch_unit.sv
// Instruction fetch stage: owns the PC, issues one word request at a time to
// instruction memory and queues returned words with their PCs for execute.
module instr_fetch_unit #(
    parameter int              XLEN      = 32,
    parameter logic [XLEN-1:0] RESET_PC  = '0,
    parameter int              BUF_DEPTH = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_gnt,
    input  logic            imem_rvalid,
    input  logic [XLEN-1:0] imem_rdata,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            instr_valid,
    input  logic            instr_ready,
    output logic [XLEN-1:0] instr,
    output logic [XLEN-1:0] instr_pc
);

    localparam int PW = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
    localparam int CW = $clog2(BUF_DEPTH + 1);
    localparam logic [CW-1:0]   DEPTH_C    = CW'(BUF_DEPTH);
    localparam logic [XLEN-1:0] ALIGN_MASK = ~XLEN'(3);
    localparam logic [XLEN-1:0] PC_STEP    = XLEN'(4);

    typedef enum logic [1:0] {
        FETCH,
        WAIT,
        DROP
    } state_e;

    state_e          state_q, state_d;
    logic [XLEN-1:0] fetchPc_q, fetchPc_d;
    logic [XLEN-1:0] reqPc_q, reqPc_d;
    logic [PW-1:0]   rdPtr_q, rdPtr_d;
    logic [PW-1:0]   wrPtr_q, wrPtr_d;
    logic [CW-1:0]   count_q, count_d;
    logic [XLEN-1:0] dataMem_q [BUF_DEPTH];
    logic [XLEN-1:0] pcMem_q   [BUF_DEPTH];

    logic pop;
    logic push;
    logic gntFire;
    logic rspDone;

    assign pop         = (count_q != '0) && instr_ready;
    assign instr_valid = (count_q != '0);
    assign instr       = dataMem_q[rdPtr_q];
    assign instr_pc    = pcMem_q[rdPtr_q];
    assign imem_addr   = fetchPc_q;

    // A pop in the same cycle frees a slot, so a full buffer may still request;
    // gating with rst_n keeps the request low for the whole reset interval.
    assign imem_req = rst_n && (state_q == FETCH) && ((count_q < DEPTH_C) || pop);
    assign gntFire  = imem_req && imem_gnt;
    assign rspDone  = (state_q != FETCH) && imem_rvalid;
    assign push     = (state_q == WAIT) && imem_rvalid && !redirect_valid;

    always_comb begin
        state_d   = state_q;
        fetchPc_d = fetchPc_q;
        reqPc_d   = reqPc_q;
        rdPtr_d   = rdPtr_q;
        wrPtr_d   = wrPtr_q;
        count_d   = count_q;

        if (redirect_valid) begin
            fetchPc_d = redirect_pc & ALIGN_MASK;
            rdPtr_d   = '0;
            wrPtr_d   = '0;
            count_d   = '0;
            // Any request still owed a response must have that response swallowed.
            if (state_q == FETCH) begin
                state_d = gntFire ? DROP : FETCH;
            end else begin
                state_d = rspDone ? FETCH : DROP;
            end
        end else begin
            case (state_q)
                FETCH: begin
                    if (gntFire) begin
                        reqPc_d   = fetchPc_q;
                        fetchPc_d = fetchPc_q + PC_STEP;
                        state_d   = WAIT;
                    end
                end
                WAIT: begin
                    if (imem_rvalid) begin
                        state_d = FETCH;
                    end
                end
                DROP: begin
                    if (imem_rvalid) begin
                        state_d = FETCH;
                    end
                end
                default: state_d = FETCH;
            endcase

            if (push) begin
                wrPtr_d = wrPtr_q + PW'(1);
            end
            if (pop) begin
                rdPtr_d = rdPtr_q + PW'(1);
            end
            case ({push, pop})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= FETCH;
            fetchPc_q <= RESET_PC & ALIGN_MASK;
            reqPc_q   <= '0;
            rdPtr_q   <= '0;
            wrPtr_q   <= '0;
            count_q   <= '0;
            for (int i = 0; i < BUF_DEPTH; i++) begin
                dataMem_q[i] <= '0;
                pcMem_q[i]   <= '0;
            end
        end else begin
            state_q   <= state_d;
            fetchPc_q <= fetchPc_d;
            reqPc_q   <= reqPc_d;
            rdPtr_q   <= rdPtr_d;
            wrPtr_q   <= wrPtr_d;
            count_q   <= count_d;
            if (push) begin
                dataMem_q[wrPtr_q] <= imem_rdata;
                pcMem_q[wrPtr_q]   <= reqPc_q;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst_n) begin
            assert (count_q <= DEPTH_C);
            assert (imem_addr[1:0] == 2'b00);
        end
    end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: a reactive memory model feeds a scoreboard of
// expected {instr, pc} pairs that is checked whenever the execute side consumes.
module tb_instr_fetch_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr;
    logic [31:0] instr_pc;

    int errorCount = 0;
    int checkCount = 0;

    // Memory / reference model state
    logic [63:0] sbQueue[$];
    logic [31:0] expAddr;
    logic [31:0] respData;
    logic [31:0] respPc;
    int          respCnt;
    bit          respPending;
    bit          outstanding;
    bit          dropPending;
    bit          pushedLast;
    bit          gntAllowed;
    bit          useDead;
    bit          forceRvalid;
    int          latency;
    int          gntCount;

    instr_fetch_unit dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_gnt       (imem_gnt),
        .imem_rvalid    (imem_rvalid),
        .imem_rdata     (imem_rdata),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .instr_valid    (instr_valid),
        .instr_ready    (instr_ready),
        .instr          (instr),
        .instr_pc       (instr_pc)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] dataFor(input logic [31:0] a);
        return {a[15:0], ~a[31:16]} ^ 32'h1357_9BDF;
    endfunction

    task automatic checkOutput(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checkCount++;
        if (act !== exp) begin
            errorCount++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // Called at posedge+1; asserts reset asynchronously and restarts the model.
    task automatic applyReset(input bit checkVals, input bit stale);
        rst_n          = 1'b0;
        imem_gnt       = 1'b0;
        redirect_valid = 1'b0;
        imem_rvalid    = stale;
        imem_rdata     = 32'hBAD0_BAD0;
        #1;
        if (checkVals) begin
            checkOutput("rst_req",   imem_req,    0);
            checkOutput("rst_addr",  imem_addr,   0);
            checkOutput("rst_valid", instr_valid, 0);
            checkOutput("rst_instr", instr,       0);
            checkOutput("rst_ipc",   instr_pc,    0);
        end
        repeat (2) @(posedge clk);
        #1;
        sbQueue.delete();
        expAddr     = 32'h0;
        respPending = 0;
        outstanding = 0;
        dropPending = 0;
        pushedLast  = 0;
        imem_rvalid = 1'b0;
        rst_n       = 1'b1;
        #1;
        checkOutput("first_req",  imem_req,  1);
        checkOutput("first_addr", imem_addr, 0);
    endtask

    // One clock of stimulus: memory response, scoreboard pop, grant, push, redirect.
    task automatic applyStimulus(input bit rdy, input bit redir, input logic [31:0] rpc);
        bit          rsp;
        logic [31:0] rspD;
        logic [31:0] rspP;
        logic [63:0] expEntry;
        instr_ready    = rdy;
        redirect_valid = redir;
        redirect_pc    = rpc;
        imem_gnt       = 1'b0;
        rsp            = 0;
        if (respPending) begin
            respCnt--;
            if (respCnt == 0) begin
                rsp         = 1;
                respPending = 0;
            end
        end
        rspD        = respData;
        rspP        = respPc;
        imem_rvalid = rsp | forceRvalid;
        imem_rdata  = rsp ? rspD : 32'h0BAD_F00D;
        #1;
        if (pushedLast) checkOutput("latency_valid", instr_valid, 1);
        if (instr_valid && instr_ready) begin
            if (sbQueue.size() == 0) begin
                checkOutput("unexpected_instr", instr_valid, 0);
            end else begin
                expEntry = sbQueue.pop_front();
                checkOutput("instr",    instr,    {32'h0, expEntry[63:32]});
                checkOutput("instr_pc", instr_pc, {32'h0, expEntry[31:0]});
            end
        end
        pushedLast = 0;
        if (rsp) begin
            if (!dropPending && !redir) begin
                sbQueue.push_back({rspD, rspP});
                pushedLast = 1;
            end
            dropPending = 0;
            outstanding = 0;
        end
        if (imem_req && gntAllowed) begin
            imem_gnt = 1'b1;
            gntCount++;
            checkOutput("imem_addr", imem_addr, expAddr);
            respPending = 1;
            respCnt     = latency;
            respPc      = expAddr;
            respData    = useDead ? 32'hDEAD_BEEF : dataFor(expAddr);
            outstanding = 1;
            expAddr     = expAddr + 32'd4;
        end
        if (redir) begin
            sbQueue.delete();
            expAddr    = rpc & ~32'd3;
            pushedLast = 0;
            if (outstanding) dropPending = 1;
        end
        @(posedge clk);
        #1;
        imem_gnt       = 1'b0;
        imem_rvalid    = 1'b0;
        redirect_valid = 1'b0;
    endtask

    task automatic runCycles(input int n, input bit rdy);
        for (int i = 0; i < n; i++) applyStimulus(rdy, 0, 32'h0);
    endtask

    task automatic runUntilGnt(input bit rdy, input int maxCycles);
        int startCount;
        startCount = gntCount;
        for (int i = 0; i < maxCycles && gntCount == startCount; i++) begin
            applyStimulus(rdy, 0, 32'h0);
        end
        if (gntCount == startCount) checkOutput("gnt_timeout", gntCount, startCount + 1);
    endtask

    initial begin
        int startG;
        rst_n          = 1'b1;
        imem_gnt       = 1'b0;
        imem_rvalid    = 1'b0;
        imem_rdata     = 32'h0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        instr_ready    = 1'b0;
        gntAllowed     = 1;
        useDead        = 0;
        forceRvalid    = 0;
        latency        = 1;
        gntCount       = 0;
        @(posedge clk);
        #1;
        applyReset(1, 0);

        // Streaming fetch: addresses 0,4,8,... each word shown the cycle after rvalid
        runCycles(8, 1);

        // Stalled consumer fills the buffer and stops requesting
        applyReset(0, 0);
        startG = gntCount;
        runCycles(10, 0);
        checkOutput("buf_gnts", gntCount - startG, 2);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(0, 0, 32'h0);
            checkOutput("full_req",    imem_req,    0);
            checkOutput("hold_valid",  instr_valid, 1);
            checkOutput("hold_instr",  instr,       dataFor(32'h0));
            checkOutput("hold_pc",     instr_pc,    0);
        end
        runUntilGnt(1, 4);
        runCycles(4, 1);

        // Redirect while waiting: late 0xDEADBEEF response must vanish
        latency = 4;
        useDead = 1;
        runUntilGnt(1, 10);
        useDead = 0;
        latency = 1;
        applyStimulus(1, 1, 32'h100);
        checkOutput("flush_valid", instr_valid, 0);
        checkOutput("drop_req",    imem_req,    0);
        runUntilGnt(1, 10);

        // Misaligned redirect target is word aligned
        gntAllowed = 0;
        runCycles(3, 1);
        applyStimulus(1, 1, 32'h203);
        checkOutput("align_addr", imem_addr, 32'h200);
        checkOutput("align_req",  imem_req,  1);
        gntAllowed = 1;
        latency    = 2;
        runUntilGnt(1, 4);

        // Redirect coinciding with the response: no drop state needed
        applyStimulus(1, 0, 32'h0);
        applyStimulus(1, 1, 32'h300);
        checkOutput("same_req",   imem_req,    1);
        checkOutput("same_addr",  imem_addr,   32'h300);
        checkOutput("same_valid", instr_valid, 0);
        latency = 5;
        runUntilGnt(1, 4);

        // Two redirects against one outstanding request
        applyStimulus(1, 1, 32'h40);
        applyStimulus(1, 1, 32'h80);
        latency = 3;
        runUntilGnt(1, 10);

        // Reset pulse while waiting, stale response afterwards
        applyReset(1, 1);
        gntAllowed  = 0;
        forceRvalid = 1;
        applyStimulus(1, 0, 32'h0);
        forceRvalid = 0;
        gntAllowed  = 1;
        checkOutput("stale_valid", instr_valid, 0);
        latency = 1;
        runUntilGnt(1, 4);

        // PC wraps past the top of the address space
        gntAllowed = 0;
        runCycles(4, 1);
        applyStimulus(1, 1, 32'hFFFF_FFFC);
        gntAllowed = 1;
        runUntilGnt(1, 4);
        runUntilGnt(1, 6);
        runCycles(4, 1);
        checkOutput("drained", sbQueue.size(), 0);

        $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
        $finish;
    end

endmodule
